// File: rtl/iir_bist_sched.sv
// ============================================================================
// iir_bist_sched
// ----------------------------------------------------------------------------
// Built-in self-test scheduler for the on-chip IIR filter.
//
// A run drives NUM_VECTORS pseudo-random words from a 32-bit LFSR into the
// filter. Each word is held for SETTLE_CYCLES cycles so the filter can
// settle. The filter output is then folded into a 32-bit MISR. When the last
// vector has been captured, done rises and signature holds the final MISR
// value. One run therefore reduces to a single signature compare.
//
// Ports:
//   clk          in   1       clock, all logic on posedge
//   rst          in   1       synchronous, active-high reset
//   start        in   1       run request (see handshake note below)
//   inData       out  DATA_W  vector driven to the IIR input
//   outData      in   DATA_W  IIR filter output, sampled in CAPTURE
//   busy         out  1       run in progress
//   done         out  1       run complete, signature final
//   signature    out  DATA_W  MISR contents
//   golden_sig   in   DATA_W  expected signature (only with the macro below)
//   pass         out  1       final signature == golden_sig (macro only)
//   dbg_state    out  3       current FSM state, for checkers and debug
//
// Optional feature macro: IIR_BIST_GOLDEN_CMP_EN
//   When defined, the golden_sig input and the registered pass output are
//   added. When undefined, neither port exists and no comparator is built.
//
// Handshake (start/busy/done):
//   start is sampled on every posedge. It is accepted only in IDLE or DONE,
//   where busy=0. It is ignored while busy=1. On the accepting edge, done
//   drops and busy rises. busy stays high until the edge that raises done.
//   done then holds, together with a frozen signature, until the next
//   accepted start or until rst. rst has priority over start.
//
// dbg_state encoding: IDLE=0, APPLY=1, SETTLE=2, CAPTURE=3, DONE=4.
// ============================================================================
module iir_bist_sched #(
    parameter int                DATA_W        = 32,
    parameter int                SETTLE_CYCLES = 30,
    parameter int                NUM_VECTORS   = 16,
    parameter logic [DATA_W-1:0] SEED          = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] inData,
    input  logic [DATA_W-1:0] outData,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] signature,
`ifdef IIR_BIST_GOLDEN_CMP_EN
    input  logic [DATA_W-1:0] golden_sig,
    output logic              pass,
`endif
    output logic [2:0]        dbg_state
);

    // The settle counter runs up to SETTLE_CYCLES on the last SETTLE edge,
    // and the vector counter never exceeds NUM_VECTORS-1. Sizing both to
    // hold their full parameter value means neither counter can wrap.
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int VC_W = $clog2(NUM_VECTORS + 1);

    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [VC_W-1:0] VEC_LAST    = VC_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] lfsr;
    logic [SC_W-1:0]   settle_cnt;
    logic [VC_W-1:0]   vec_cnt;
    logic [DATA_W-1:0] misr_next;

    // The LFSR and the MISR share one feedback polynomial, with taps at
    // bits 31, 21, 1 and 0. The taps are defined only for DATA_W = 32.
    function automatic logic [DATA_W-1:0] poly_shift(input logic [DATA_W-1:0] cur);
        return {cur[DATA_W-2:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
    endfunction

    // MISR update for the CAPTURE edge. The same value is used both for the
    // signature register and for the golden compare, so pass matches the
    // signature that done presents.
    always_comb begin
        misr_next = poly_shift(signature) ^ outData;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inData     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            signature  <= '0;
            lfsr       <= SEED;
            settle_cnt <= '0;
            vec_cnt    <= '0;
`ifdef IIR_BIST_GOLDEN_CMP_EN
            pass       <= 1'b0;
`endif
        end else begin
            case (state)
                // IDLE and DONE accept start in the same way. A start in DONE
                // restarts the run. inData keeps its last vector until the
                // first APPLY of the new run.
                IDLE, DONE: begin
                    if (start) begin
                        state     <= APPLY;
                        signature <= '0;
                        lfsr      <= SEED;
                        vec_cnt   <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
`ifdef IIR_BIST_GOLDEN_CMP_EN
                        pass      <= 1'b0;
`endif
                    end
                end

                APPLY: begin
                    inData     <= lfsr;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end

                // The counter advances on every SETTLE edge, including the
                // edge that leaves SETTLE. This keeps the dwell at exactly
                // SETTLE_CYCLES cycles.
                SETTLE: begin
                    settle_cnt <= settle_cnt + SC_W'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    signature <= misr_next;
                    lfsr      <= poly_shift(lfsr);
                    if (vec_cnt == VEC_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef IIR_BIST_GOLDEN_CMP_EN
                        pass  <= (misr_next == golden_sig);
`endif
                    end else begin
                        vec_cnt <= vec_cnt + VC_W'(1);
                        state   <= APPLY;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_bist_sched.sv
// ============================================================================
// tb_iir_bist_sched
// ----------------------------------------------------------------------------
// Two instances of the scheduler are built:
//   u_small: SETTLE_CYCLES=2, NUM_VECTORS=3. Its filter stand-in is either
//            zero, or a loopback of inData XORed with a per-run key.
//   u_def  : default parameters, in loopback.
// The driver pushes the expected vectors, signature, latency and pass for
// each run. Per-instance monitors pop those values and compare them against
// what the DUT presents.
// ============================================================================
module tb_iir_bist_sched;
    localparam int S   = 2;
    localparam int N   = 3;
    localparam int DS  = 30;
    localparam int DN  = 16;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_start = 1'b0;
    logic        d_start = 1'b0;
    logic        zero_mode = 1'b0;
    logic [31:0] key = 32'h0;
    logic [31:0] s_in, s_out, s_sig, d_in, d_out, d_sig;
    logic        s_busy, s_done, d_busy, d_done;
    logic [2:0]  s_dbg, d_dbg;
`ifdef IIR_BIST_GOLDEN_CMP_EN
    logic [31:0] golden = 32'h0;
    logic        s_pass, d_pass;
`endif

    assign s_out = zero_mode ? 32'h0 : (s_in ^ key);
    assign d_out = d_in;

    iir_bist_sched #(.DATA_W(32), .SETTLE_CYCLES(S), .NUM_VECTORS(N), .SEED(SEED)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .inData(s_in), .outData(s_out),
        .busy(s_busy), .done(s_done), .signature(s_sig),
`ifdef IIR_BIST_GOLDEN_CMP_EN
        .golden_sig(golden), .pass(s_pass),
`endif
        .dbg_state(s_dbg));

    iir_bist_sched u_def (
        .clk(clk), .rst(rst), .start(d_start), .inData(d_in), .outData(d_out),
        .busy(d_busy), .done(d_done), .signature(d_sig),
`ifdef IIR_BIST_GOLDEN_CMP_EN
        .golden_sig(32'h0), .pass(d_pass),
`endif
        .dbg_state(d_dbg));

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] s_vq[$];
    logic [31:0] exp_q[$];
    int          s_acc_q[$];
    logic        s_pass_q[$];
    logic [31:0] d_vq[$];
    logic [31:0] d_exp_q[$];
    int          d_acc_q[$];
    logic        d_pass_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Shift left by one and feed the parity of the tapped bits into bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x << 1) | {31'b0, ^(x & 32'h8020_0003)};
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] d);
        return lfsr_step(sig) ^ d;
    endfunction

    task automatic push_small(input bit zm, input logic [31:0] k, output logic [31:0] sig);
        logic [31:0] v;
        v   = SEED;
        sig = 32'h0;
        for (int i = 0; i < N; i++) begin
            s_vq.push_back(v);
            sig = misr_step(sig, zm ? 32'h0 : (v ^ k));
            v   = lfsr_step(v);
        end
        exp_q.push_back(sig);
`ifdef IIR_BIST_GOLDEN_CMP_EN
        s_pass_q.push_back(sig == golden);
`endif
    endtask

    task automatic push_def();
        logic [31:0] v;
        logic [31:0] sig;
        v   = SEED;
        sig = 32'h0;
        for (int i = 0; i < DN; i++) begin
            d_vq.push_back(v);
            sig = misr_step(sig, v);
            v   = lfsr_step(v);
        end
        d_exp_q.push_back(sig);
        d_pass_q.push_back(sig == 32'h0);
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int n;
        n = 0;
        while (!(sel ? d_done : s_done) && n < budget) begin
            tick();
            n++;
        end
        if (!(sel ? d_done : s_done)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1 (inst %0d)", budget, sel);
        end
    endtask

    // Launch one run on u_small. When hold is set, start stays high until
    // done. A nonzero poke adds a one-cycle start pulse that many cycles
    // into the run.
    task automatic run_small(input bit zm, input logic [31:0] k, input bit hold,
                             input int poke, output logic [31:0] sig);
        zero_mode = zm;
        key       = k;
        push_small(zm, k, sig);
        s_start = 1'b1;
        tick();
        s_acc_q.push_back(cyc);
        if (!hold) s_start = 1'b0;
        if (poke > 0) begin
            repeat (poke - 1) tick();
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
        end
        wait_done(1'b0, 100);
        s_start = 1'b0;
    endtask

    // ---------------- monitors ----------------
    logic [31:0] s_prev_in;
    logic        s_prev_done;
    int          s_busy_cnt;

    always @(negedge clk) begin
        if (rst) begin
            s_prev_done = 1'b0;
            s_busy_cnt  = 0;
        end else begin
            if (s_busy) s_busy_cnt++;
            if (s_busy && s_in !== s_prev_in) begin
                if (s_vq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL s_vec_extra: got 0x%08h, expected no vector", s_in);
                end else begin
                    check("s_vector", s_in, s_vq.pop_front());
                end
            end
            if (s_done && !s_prev_done) begin
                if (exp_q.size() == 0 || s_acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL s_done_unexpected: got done=1, expected no run pending");
                end else begin
                    check("s_signature", s_sig, exp_q.pop_front());
                    check("s_latency", 32'(cyc - s_acc_q.pop_front()), 32'(N * (S + 2)));
                    check("s_busy_cycles", 32'(s_busy_cnt), 32'(N * (S + 2)));
`ifdef IIR_BIST_GOLDEN_CMP_EN
                    check("s_pass", {31'b0, s_pass}, {31'b0, s_pass_q.pop_front()});
`endif
                end
                s_busy_cnt = 0;
            end
            s_prev_done = s_done;
        end
        s_prev_in = s_in;
    end

    logic [31:0] d_prev_in;
    logic        d_prev_done;

    always @(negedge clk) begin
        if (rst) begin
            d_prev_done = 1'b0;
        end else begin
            if (d_busy && d_in !== d_prev_in) begin
                if (d_vq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL d_vec_extra: got 0x%08h, expected no vector", d_in);
                end else begin
                    check("d_vector", d_in, d_vq.pop_front());
                end
            end
            if (d_done && !d_prev_done) begin
                if (d_exp_q.size() == 0 || d_acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL d_done_unexpected: got done=1, expected no run pending");
                end else begin
                    check("d_signature", d_sig, d_exp_q.pop_front());
                    check("d_latency", 32'(cyc - d_acc_q.pop_front()), 32'(DN * (DS + 2)));
`ifdef IIR_BIST_GOLDEN_CMP_EN
                    check("d_pass", {31'b0, d_pass}, {31'b0, d_pass_q.pop_front()});
`endif
                end
            end
            d_prev_done = d_done;
        end
        d_prev_in = d_in;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] sig;
        logic [31:0] k;
        bit          zm;

        // Reset values.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_inData", s_in, 32'h0);
        check("rst_busy", {31'b0, s_busy}, 32'h0);
        check("rst_done", {31'b0, s_done}, 32'h0);
        check("rst_signature", s_sig, 32'h0);
        check("rst_dbg_state", {29'b0, s_dbg}, 32'h0);
        check("rst_d_dbg_state", {29'b0, d_dbg}, 32'h0);
        rst = 1'b0;
        tick();

        // Loopback run.
`ifdef IIR_BIST_GOLDEN_CMP_EN
        golden = 32'h6;
`endif
        run_small(1'b0, 32'h0, 1'b0, 0, sig);
        check("loop_sig_const", s_sig, 32'h6);
`ifdef IIR_BIST_GOLDEN_CMP_EN
        check("pass_golden6", {31'b0, s_pass}, 32'h1);
`endif
        repeat (4) tick();

        // Filter output tied to zero.
        run_small(1'b1, 32'h0, 1'b0, 0, sig);
        check("zero_sig_const", s_sig, 32'h0);
        tick();

        // Reset during the second vector's SETTLE.
        zero_mode = 1'b0;
        key       = 32'h0;
        push_small(1'b0, 32'h0, sig);
        s_start = 1'b1;
        tick();
        s_acc_q.push_back(cyc);
        s_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_inData", s_in, 32'h0);
        check("midrst_busy", {31'b0, s_busy}, 32'h0);
        check("midrst_done", {31'b0, s_done}, 32'h0);
        check("midrst_signature", s_sig, 32'h0);
`ifdef IIR_BIST_GOLDEN_CMP_EN
        check("midrst_pass", {31'b0, s_pass}, 32'h0);
`endif
        rst = 1'b0;
        s_vq.delete();
        exp_q.delete();
        s_acc_q.delete();
        s_pass_q.delete();
        tick();

        // A fresh run after the reset gives the same result as the first run.
`ifdef IIR_BIST_GOLDEN_CMP_EN
        golden = 32'h7;
`endif
        run_small(1'b0, 32'h0, 1'b0, 0, sig);
        check("rerun_sig_const", s_sig, 32'h6);
`ifdef IIR_BIST_GOLDEN_CMP_EN
        check("pass_golden7", {31'b0, s_pass}, 32'h0);
`endif
        tick();

        // start held high for the whole run.
        run_small(1'b0, 32'h0, 1'b1, 0, sig);
        repeat (3) tick();
        check("hold_done_stays", {31'b0, s_done}, 32'h1);
        check("hold_sig_const", s_sig, 32'h6);

        // A start pulse in DONE restarts the run.
        push_small(1'b0, 32'h0, sig);
        s_start = 1'b1;
        tick();
        s_acc_q.push_back(cyc);
        s_start = 1'b0;
        check("restart_done_drop", {31'b0, s_done}, 32'h0);
        check("restart_busy", {31'b0, s_busy}, 32'h1);
        wait_done(1'b0, 100);
        check("restart_sig_const", s_sig, 32'h6);

        // Random runs: output key, zero mode, golden value, idle gap, and
        // stray start pulses while busy.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            zm = ($urandom_range(0, 3) == 0);
            k  = $urandom;
`ifdef IIR_BIST_GOLDEN_CMP_EN
            golden = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
`endif
            run_small(zm, k, 1'b0, $urandom_range(0, 8), sig);
`ifdef IIR_BIST_GOLDEN_CMP_EN
            // Exercise the matching case of the comparator as well.
            if (r == 9) begin
                golden = s_sig;
                push_small(zm, k, sig);
                s_start = 1'b1;
                tick();
                s_acc_q.push_back(cyc);
                s_start = 1'b0;
                wait_done(1'b0, 100);
                check("rand_pass_match", {31'b0, s_pass}, 32'h1);
            end
`endif
        end

        // Default-parameter instance, loopback.
        push_def();
        d_start = 1'b1;
        tick();
        d_acc_q.push_back(cyc);
        d_start = 1'b0;
        wait_done(1'b1, 700);

        repeat (3) tick();
        check("drain_queues", 32'(s_vq.size() + exp_q.size() + d_vq.size() + d_exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
